// File: rtl/led_fader.sv
// Per-LED PWM fader: each LED ramps its brightness level toward a target (on = max_level, off = 0)
// by one step per tick and drives its pin with a registered level-vs-counter compare.

module led_fader_lane #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] target,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic [PWM_BITS-1:0] level,
  output logic                led,
  output logic                diff
);
  typedef enum logic [1:0] {IDLE, RISE, FALL} dir_t;
  dir_t dir;

  // Direction is recomputed every cycle, so a target change mid-ramp simply reverses from here.
  always_comb begin
    dir = IDLE;
    if (level < target)      dir = RISE;
    else if (level > target) dir = FALL;
  end

  assign diff = (dir != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= '0;
      led   <= 1'b0;
    end else begin
      led <= (level > pwm_cnt);
      if (!enable) level <= '0;
      else if (tick) begin
        case (dir)
          RISE:    level <= level + 1'b1;
          FALL:    level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end
endmodule

module led_fader #(
  parameter int LED      = 4,
  parameter int CLKFREQ  = 100,
  parameter int PWM_BITS = 8,
  parameter int FADE_US  = 250000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [PWM_BITS-1:0] max_level,
  input  logic [LED-1:0]      led_in,
  output logic [LED-1:0]      led_out,
  output logic                busy
);
  localparam int FULL     = 2**PWM_BITS - 1;
  localparam int STEP_RAW = CLKFREQ * FADE_US / FULL;
  localparam int STEP     = (STEP_RAW < 1) ? 1 : STEP_RAW;
  localparam int STEP_W   = (STEP > 1) ? $clog2(STEP) : 1;

  logic [STEP_W-1:0]                 step_cnt;
  logic [PWM_BITS-1:0]               pwm_cnt;
  logic                              tick;
  logic [LED-1:0][PWM_BITS-1:0]      target;
  logic [LED-1:0][PWM_BITS-1:0]      level;
  logic [LED-1:0]                    diff;

  assign tick = enable && (step_cnt == STEP_W'(STEP - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
      pwm_cnt  <= '0;
      busy     <= 1'b0;
    end else if (!enable) begin
      step_cnt <= '0;
      pwm_cnt  <= '0;
      busy     <= 1'b0;
    end else begin
      step_cnt <= tick ? '0 : step_cnt + 1'b1;
      // Period of FULL cycles so that level=FULL compares high on every count.
      pwm_cnt  <= (pwm_cnt == PWM_BITS'(FULL - 1)) ? '0 : pwm_cnt + 1'b1;
      busy     <= |diff;
    end
  end

  for (genvar i = 0; i < LED; i++) begin : g_lane
    assign target[i] = led_in[i] ? max_level : '0;

    led_fader_lane #(.PWM_BITS(PWM_BITS)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .tick    (tick),
      .target  (target[i]),
      .pwm_cnt (pwm_cnt),
      .level   (level[i]),
      .led     (led_out[i]),
      .diff    (diff[i])
    );
  end
endmodule
